// File: rtl/controller_nios2e_oci_dct_packer.sv
// Packs 2-bit trace atoms into frames of up to MAX_COUNT atoms and supports a flush that leads to a terminal DONE state.
// Latency: when the last atom of a full frame is accepted at edge N, frame_valid rises after edge N+1.
// Backpressure: the output frame slot holds while frame_ready is low, atom_ready drops when the working buffer is full, and an atom offered while not ready sets the sticky overflow flag.
module controller_nios2e_oci_dct_packer #(
    parameter int MAX_COUNT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        test_ending,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_has_ended,
    output logic        overflow
);

    // A frame holds at most 15 atoms, because dct_count is 4 bits and dct_buffer is 30 bits.
    generate
        if (MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_bad_max_count
            $error("MAX_COUNT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] MAX_CNT = 4'(MAX_COUNT);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [29:0] wbuf;
    logic [3:0]  wcnt;
    logic        accept;
    logic        slot_free;
    logic        transfer;

    // atom_ready depends only on registered state, so upstream never sees a combinational loop through it.
    assign atom_ready = (state == ST_RUN) && (wcnt < MAX_CNT);
    assign accept     = atom_valid && atom_ready;
    // The output slot can take a new frame in the same cycle that the old frame is consumed.
    assign slot_free  = !frame_valid || frame_ready;
    // Accept and transfer never happen in the same cycle: accept needs wcnt < MAX in RUN, and transfer needs a full buffer or FLUSH.
    assign transfer   = slot_free && ((wcnt == MAX_CNT) || ((state == ST_FLUSH) && (wcnt != 4'd0)));

    // Next-state logic: a flush request moves to FLUSH, which finishes once both the buffer and the output slot are empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (test_ending) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((wcnt == 4'd0) && slot_free) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // State register, plus the sticky done flag that is set together with the entry into DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            test_has_ended <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_DONE) begin
                test_has_ended <= 1'b1;
            end
        end
    end

    // Working buffer: new atoms shift in at the bottom, so the oldest atom ends up in the highest occupied slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbuf <= 30'd0;
            wcnt <= 4'd0;
        end else if (transfer) begin
            wbuf <= 30'd0;
            wcnt <= 4'd0;
        end else if (accept) begin
            wbuf <= {wbuf[27:0], atom};
            wcnt <= wcnt + 4'd1;
        end
    end

    // Output slot: load it on transfer, release it on a handshake, and otherwise hold it. The data fields keep their last value after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer  <= 30'd0;
            dct_count   <= 4'd0;
            frame_valid <= 1'b0;
        end else if (transfer) begin
            dct_buffer  <= wbuf;
            dct_count   <= wcnt;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky overflow flag: an atom offered in RUN while the buffer is full is dropped. Offers made in FLUSH or DONE are ignored without setting the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if ((state == ST_RUN) && atom_valid && !atom_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller_nios2e_oci_dct_packer.sv
// Directed and randomized checks of the DCT atom packer against a queue-based reference model.
// Latency: one check point per clock, sampled 1 time unit after the rising edge.
// Backpressure: frame_ready is toggled to hold frames, and atoms are offered to exercise the overflow flag.
module tb_controller_nios2e_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom = 2'd0;
    logic        atom_ready;
    logic        test_ending = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;
    logic        overflow;

    logic        av1 = 1'b0;
    logic [1:0]  at1 = 2'd0;
    logic        ar1;
    logic        te1 = 1'b0;
    logic        fr1 = 1'b0;
    logic        fv1;
    logic [29:0] db1;
    logic [3:0]  dc1;
    logic        th1;
    logic        ov1;

    int n_tests = 0;
    int n_fail = 0;
    logic [1:0] aq[$];

    controller_nios2e_oci_dct_packer #(.MAX_COUNT(15)) u_dut (
        .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom),
        .atom_ready(atom_ready), .test_ending(test_ending), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_has_ended(test_has_ended), .overflow(overflow)
    );

    controller_nios2e_oci_dct_packer #(.MAX_COUNT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .atom_valid(av1), .atom(at1),
        .atom_ready(ar1), .test_ending(te1), .frame_ready(fr1),
        .frame_valid(fv1), .dct_buffer(db1), .dct_count(dc1),
        .test_has_ended(th1), .overflow(ov1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: atoms in arrival order, with the oldest atom in the most significant occupied slot.
    function automatic logic [31:0] pack(input int start, input int n);
        logic [31:0] b = 32'd0;
        for (int i = 0; i < n; i++) begin
            b = (b << 2) | 32'(aq[start + i]);
        end
        return b;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        atom_valid = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b0;
        av1 = 1'b0;
        fr1 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        aq.delete();
    endtask

    // Offer atoms only while atom_ready is high, so that no atom is dropped. Stops after n acceptances or when the cycle budget runs out.
    task automatic send_atoms(input int n, input bit rnd, input logic [1:0] fixed);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 200) begin
            if (atom_ready) begin
                atom_valid = 1'b1;
                atom = rnd ? 2'($urandom) : fixed;
                aq.push_back(atom);
                sent++;
            end else begin
                atom_valid = 1'b0;
            end
            tick();
            guard++;
        end
        atom_valid = 1'b0;
        chk("send_done", sent, n);
    endtask

    initial begin
        int cons;
        int exp_n;
        int g;
        bit exp_ovf;
        bit exp_rdy;
        logic [1:0] q1[$];
        int c1;

        // Reset state.
        tick();
        tick();
        chk("rst_fv", frame_valid, 0);
        chk("rst_buf", dct_buffer, 0);
        chk("rst_cnt", dct_count, 0);
        chk("rst_done", test_has_ended, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rdy", atom_ready, 1);
        reset_n = 1'b1;

        // Full frame of fifteen 01 atoms, with frame_ready held high.
        do_reset();
        frame_ready = 1'b1;
        send_atoms(15, 1'b0, 2'b01);
        chk("full_fv_early", frame_valid, 0);
        chk("full_rdy_full", atom_ready, 0);
        tick();
        chk("full_fv", frame_valid, 1);
        chk("full_cnt", dct_count, 15);
        chk("full_buf", dct_buffer, 32'h15555555);
        tick();
        chk("full_fv_clr", frame_valid, 0);
        chk("full_cnt_keep", dct_count, 15);
        chk("full_rdy_again", atom_ready, 1);

        // Backpressure: 30 atoms accepted while the first frame is held, then a 31st atom is dropped.
        do_reset();
        send_atoms(30, 1'b1, 2'd0);
        chk("bp_fv", frame_valid, 1);
        chk("bp_buf1", dct_buffer, pack(0, 15));
        chk("bp_rdy_low", atom_ready, 0);
        chk("bp_ovf_before", overflow, 0);
        atom_valid = 1'b1;
        atom = 2'($urandom);
        tick();
        atom_valid = 1'b0;
        chk("bp_ovf_31", overflow, 1);
        tick();
        tick();
        chk("bp_hold_fv", frame_valid, 1);
        chk("bp_hold_buf", dct_buffer, pack(0, 15));
        chk("bp_hold_cnt", dct_count, 15);
        frame_ready = 1'b1;
        tick();
        chk("bp_b2b_fv", frame_valid, 1);
        chk("bp_buf2", dct_buffer, pack(15, 15));
        tick();
        chk("bp_fv_clr", frame_valid, 0);

        // Ordering: atoms 3, 2, 1, 0 followed by a flush.
        do_reset();
        frame_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            atom_valid = 1'b1;
            atom = 2'(i);
            tick();
        end
        atom_valid = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("ord_flush_rdy", atom_ready, 0);
        tick();
        chk("ord_fv", frame_valid, 1);
        chk("ord_cnt", dct_count, 4);
        chk("ord_buf", dct_buffer, 32'h000000E4);
        tick();
        chk("ord_done", test_has_ended, 1);
        chk("ord_fv_clr", frame_valid, 0);
        atom_valid = 1'b1;
        tick();
        atom_valid = 1'b0;
        chk("done_ign_ovf", overflow, 0);
        chk("done_ign_fv", frame_valid, 0);

        // Empty flush, with an atom offered during FLUSH that must be ignored.
        do_reset();
        frame_ready = 1'b1;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        atom_valid = 1'b1;
        tick();
        atom_valid = 1'b0;
        chk("empty_done", test_has_ended, 1);
        chk("empty_fv", frame_valid, 0);
        chk("flush_ign_ovf", overflow, 0);

        // Flush request in the same cycle that the 15th atom is accepted.
        do_reset();
        frame_ready = 1'b1;
        send_atoms(14, 1'b1, 2'd0);
        atom_valid = 1'b1;
        atom = 2'($urandom);
        aq.push_back(atom);
        test_ending = 1'b1;
        tick();
        atom_valid = 1'b0;
        test_ending = 1'b0;
        tick();
        chk("sim_fv", frame_valid, 1);
        chk("sim_cnt", dct_count, 15);
        chk("sim_buf", dct_buffer, pack(0, 15));
        tick();
        chk("sim_done", test_has_ended, 1);

        // Reset asserted mid-frame: the outputs clear at once, and only atoms that arrive after reset are framed.
        do_reset();
        send_atoms(22, 1'b1, 2'd0);
        chk("mid_fv_pre", frame_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_fv_rst", frame_valid, 0);
        chk("mid_buf_rst", dct_buffer, 0);
        chk("mid_cnt_rst", dct_count, 0);
        reset_n = 1'b1;
        aq.delete();
        tick();
        tick();
        chk("mid_no_frame", frame_valid, 0);
        frame_ready = 1'b1;
        send_atoms(4, 1'b1, 2'd0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        tick();
        chk("mid_new_cnt", dct_count, 4);
        chk("mid_new_buf", dct_buffer, pack(0, 4));

        // Randomized traffic checked against the queue model, followed by a draining flush.
        do_reset();
        cons = 0;
        exp_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            atom_valid = ($urandom_range(0, 3) != 0);
            atom = 2'($urandom);
            frame_ready = ($urandom_range(0, 2) != 0);
            exp_rdy = (aq.size() - cons - (frame_valid ? 15 : 0)) < 15;
            chk("rnd_rdy", atom_ready, 32'(exp_rdy));
            if (frame_valid && frame_ready) begin
                chk("rnd_cnt", dct_count, 15);
                chk("rnd_buf", dct_buffer, pack(cons, 15));
                cons += 15;
            end
            if (atom_valid && exp_rdy) aq.push_back(atom);
            if (atom_valid && !exp_rdy) exp_ovf = 1'b1;
            tick();
        end
        atom_valid = 1'b0;
        chk("rnd_ovf", overflow, 32'(exp_ovf));
        test_ending = 1'b1;
        frame_ready = 1'b1;
        g = 0;
        while (!test_has_ended && g < 100) begin
            if (frame_valid && frame_ready) begin
                exp_n = (aq.size() - cons) < 15 ? (aq.size() - cons) : 15;
                chk("fl_cnt", dct_count, exp_n);
                chk("fl_buf", dct_buffer, pack(cons, exp_n));
                cons += exp_n;
            end
            tick();
            test_ending = 1'b0;
            g++;
        end
        chk("fl_done", test_has_ended, 1);
        chk("fl_all_atoms", cons, aq.size());

        // MAX_COUNT = 1: each atom is emitted as its own frame.
        do_reset();
        fr1 = 1'b1;
        c1 = 0;
        for (int c = 0; c < 20; c++) begin
            av1 = ar1;
            at1 = 2'($urandom);
            if (fv1 && fr1) begin
                chk("m1_cnt", dc1, 1);
                chk("m1_buf", db1, 32'(q1[c1]));
                c1++;
            end
            if (av1 && ar1) q1.push_back(at1);
            tick();
        end
        av1 = 1'b0;
        chk("m1_frames", (c1 >= 5) ? 1 : 0, 1);
        chk("m1_ovf", ov1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_nios2e_oci_dct_packer.md
CONTROLLER_NIOS2E_OCI_DCT_PACKER -- requirements
Module: controller_nios2e_oci_dct_packer

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 15, meaning atoms per full frame; legal range 1..15, any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-004 SHALL have port atom_valid, input, 1, a trace atom is offered this cycle.
REQ-005 SHALL have port atom, input, 2, trace atom code; all four values are legal data.
REQ-006 SHALL have port atom_ready, output, 1, the packer accepts an offered atom this cycle.
REQ-007 SHALL have port test_ending, input, 1, flush request, level or pulse.
REQ-008 SHALL have port frame_ready, input, 1, the downstream consumer takes the frame this cycle.
REQ-009 SHALL have port frame_valid, output, 1, dct_buffer/dct_count hold a frame.
REQ-010 SHALL have port dct_buffer, output, 30, packed 2-bit atoms.
REQ-011 SHALL have port dct_count, output, 4, number of valid atoms in dct_buffer (1..MAX_COUNT).
REQ-012 SHALL have port test_has_ended, output, 1, sticky flush-complete flag.
REQ-013 SHALL have port overflow, output, 1, sticky dropped-atom flag.

Function
REQ-014 SHALL hold a working buffer wbuf[29:0] and wcnt[3:0] plus a registered output slot (dct_buffer, dct_count, frame_valid).
REQ-015 SHALL implement states RUN, FLUSH and DONE; reset state RUN.
REQ-016 SHALL drive atom_ready = 1 only in RUN with wcnt < MAX_COUNT; combinational from state and wcnt only.
REQ-017 SHALL, on atom_valid && atom_ready, set wbuf <= {wbuf[27:0], atom} and wcnt <= wcnt+1; the oldest atom sits in the highest occupied slot, and unused upper bits are zero.
REQ-018 SHALL transfer wbuf/wcnt to the output slot when (wcnt == MAX_COUNT, or state is FLUSH with wcnt > 0) and the slot is free (frame_valid == 0, or frame_valid && frame_ready in the same cycle); on transfer, wbuf <= 0, wcnt <= 0, frame_valid <= 1.
REQ-019 SHALL give latency: last atom of a full frame accepted at edge N gives frame_valid = 1 after edge N+1.
REQ-020 SHALL hold dct_buffer, dct_count and frame_valid stable while frame_valid && !frame_ready.
REQ-021 SHALL, on frame_valid && frame_ready with no transfer in the same cycle, clear frame_valid next cycle; dct_buffer/dct_count retain their last value.
REQ-022 SHALL, when back-to-back frames are transferred, allow one frame per cycle with no bubble when frame_ready stays high.
REQ-023 SHALL take RUN -> FLUSH on any cycle with test_ending = 1; an atom accepted in that same cycle is kept and included in the flush.
REQ-024 SHALL, in FLUSH, keep atom_ready = 0; a partial frame (wcnt > 0) is transferred per REQ-018.
REQ-025 SHALL take FLUSH -> DONE when wcnt == 0 and frame_valid == 0 (or it is cleared by a handshake that cycle).
REQ-026 SHALL, in DONE, set test_has_ended = 1 and hold it until reset; test_ending and atoms are ignored.
REQ-027 SHALL set overflow = 1, sticky until reset, on atom_valid && !atom_ready in RUN; the offered atom is dropped.
REQ-028 SHALL ignore atom_valid in FLUSH and DONE without setting overflow.
REQ-029 SHALL, with MAX_COUNT = 1, emit each atom as its own frame (dct_count = 1, dct_buffer[1:0] = atom).

Reset
REQ-030 SHALL, when reset_n = 0 asynchronously, force state RUN, wbuf = 0, wcnt = 0, dct_buffer = 0, dct_count = 0, frame_valid = 0, test_has_ended = 0, overflow = 0.
REQ-031 SHALL discard a pending or partially built frame on reset mid-operation; no frame is emitted after reset_n deasserts until new atoms arrive.
REQ-032 SHALL synchronise reset_n deassertion externally; the block requires no internal synchroniser.

Verification
REQ-033 SHALL be verified with full frame: MAX_COUNT = 15, frame_ready = 1, 15 atoms of 2'b01 -> one frame, dct_count = 15, dct_buffer = 30'h15555555, frame_valid 2 edges after the last acceptance.
REQ-034 SHALL be verified with ordering: atoms 3,2,1,0 then test_ending -> frame with dct_count = 4, dct_buffer = 30'h000000E4, then test_has_ended = 1.
REQ-035 SHALL be verified with backpressure: frame_ready = 0, 31 atoms offered continuously -> first frame held stable, atom_ready low at wcnt = 15, overflow = 1 on the 31st offer, and the second frame emitted after frame_ready rises.
REQ-036 SHALL be verified with empty flush: test_ending with wcnt = 0 and no frame pending -> no frame_valid, test_has_ended = 1 within 2 cycles.
REQ-037 SHALL be verified with simultaneous events: test_ending and an accepted atom in the same cycle at wcnt = 14 -> frame dct_count = 15, then DONE.
REQ-038 SHALL be verified with reset mid-frame: reset_n low at wcnt = 7 with frame_valid = 1 -> all outputs 0 immediately, and the next frame contains only post-reset atoms.
